tile_sequencer: RTL and testbench

- Controller that sequences the tile accumulator for one layer job: N output tiles, each built from K input tiles.
- For every output tile it fetches K activation tiles from the activation buffer, strobes them into the accumulator with act_load, waits for the accumulator's ready, then advances.
- Sits between the layer-level control FSM (start/done) and the activation buffer plus tile accumulator pair.

---
 rtl/nnoc_tile_pkg.sv | 17 +
 rtl/tile_addr_gen.sv | 70 +++++++
 rtl/tile_sequencer.sv | 117 +++++++++++
 tb/tb_tile_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnoc_tile_pkg.sv
// Shared types and sizing for the tile sequencer and its address generator.
package nnoc_tile_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACC, DONE} seq_state_t;

  localparam int TILE_ROWS         = 16;
  localparam int MAX_IN_TILES_DEF  = 4;
  localparam int MAX_OUT_TILES_DEF = 16;
  localparam int K_W               = 4;
  localparam int N_W               = 5;
  localparam int IN_CNT_W  = (MAX_IN_TILES_DEF > 1) ? $clog2(MAX_IN_TILES_DEF) : 1;
  localparam int OUT_CNT_W = (MAX_OUT_TILES_DEF > 1) ? $clog2(MAX_OUT_TILES_DEF) : 1;

  function automatic logic cfg_invalid(input logic [K_W-1:0] k, input logic [N_W-1:0] n,
                                       input int max_k, input int max_n);
    return (k == '0) || (int'(k) > max_k) || (n == '0) || (int'(n) > max_n);
  endfunction
endpackage

// File: rtl/tile_addr_gen.sv
// Job address/counter bookkeeping: latches the job shape, walks contiguous tile addresses.
module tile_addr_gen
  import nnoc_tile_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [ADDR_W-1:0]    base_i,
  input  logic [K_W-1:0]       k_i,
  input  logic [N_W-1:0]       n_i,
  input  logic                 in_inc_i,
  input  logic                 out_inc_i,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [K_W-1:0]       k_o,
  output logic [OUT_CNT_W-1:0] out_cnt_o,
  output logic                 in_last_o,
  output logic                 out_last_o
);
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [IN_CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [N_W-1:0]       n_q, n_d;

  assign in_last_o  = (K_W'(in_cnt_q) == k_q - K_W'(1));
  assign out_last_o = (N_W'(out_cnt_q) == n_q - N_W'(1));
  assign addr_o     = addr_q;
  assign k_o        = k_q;
  assign out_cnt_o  = out_cnt_q;

  always_comb begin
    addr_d    = addr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    k_d       = k_q;
    n_d       = n_q;
    if (load_i) begin
      addr_d    = base_i;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      k_d       = k_i;
      n_d       = n_i;
    end else begin
      // address keeps running across tiles; it wraps naturally at 2^ADDR_W
      if (in_inc_i) begin
        addr_d   = addr_q + ADDR_W'(1);
        in_cnt_d = in_last_o ? '0 : in_cnt_q + IN_CNT_W'(1);
      end
      if (out_inc_i) out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      k_q       <= '0;
      n_q       <= '0;
    end else begin
      addr_q    <= addr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      k_q       <= k_d;
      n_q       <= n_d;
    end
  end
endmodule

// File: rtl/tile_sequencer.sv
// Layer-job controller: fetches K activation tiles per output tile and paces the accumulator.
module tile_sequencer
  import nnoc_tile_pkg::*;
#(
  parameter int ADDR_W           = 10,
  parameter int MAX_INPUT_TILES  = MAX_IN_TILES_DEF,
  parameter int MAX_OUTPUT_TILES = MAX_OUT_TILES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [K_W-1:0]    cfg_num_in_tiles,
  input  logic [N_W-1:0]    cfg_num_out_tiles,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  output logic              acc_act_load,
  output logic [K_W-1:0]    acc_num_input_tiles,
  input  logic              acc_ready,
  output logic              out_tile_done,
  output logic [N_W-1:0]    out_tile_idx
);
  seq_state_t           state_q, state_d;
  logic                 cfg_bad, load, in_inc, out_inc, in_last, out_last;
  logic                 cfg_err_q, cfg_err_d, act_load_q, act_load_d;
  logic                 tile_done_q, tile_done_d;
  logic [N_W-1:0]       tile_idx_q, tile_idx_d;
  logic [OUT_CNT_W-1:0] out_cnt;

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .base_i    (cfg_base_addr),
    .k_i       (cfg_num_in_tiles),
    .n_i       (cfg_num_out_tiles),
    .in_inc_i  (in_inc),
    .out_inc_i (out_inc),
    .addr_o    (mem_rd_addr),
    .k_o       (acc_num_input_tiles),
    .out_cnt_o (out_cnt),
    .in_last_o (in_last),
    .out_last_o(out_last)
  );

  assign cfg_bad   = cfg_invalid(cfg_num_in_tiles, cfg_num_out_tiles,
                                 MAX_INPUT_TILES, MAX_OUTPUT_TILES);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_rd_en = (state_q == ISSUE);
  assign in_inc    = mem_rd_en && mem_rd_gnt;

  assign cfg_err       = cfg_err_q;
  assign acc_act_load  = act_load_q;
  assign out_tile_done = tile_done_q;
  assign out_tile_idx  = tile_idx_q;

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    out_inc     = 1'b0;
    tile_done_d = 1'b0;
    tile_idx_d  = tile_idx_q;
    // a grant in the abort cycle still returns data, so the load strobe follows regardless
    act_load_d  = in_inc;
    cfg_err_d   = (state_q == IDLE) && start && cfg_bad;
    unique case (state_q)
      IDLE: begin
        if (start && !cfg_bad) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort)                    state_d = IDLE;
        else if (mem_rd_gnt && in_last) state_d = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (acc_ready) begin
          tile_done_d = 1'b1;
          tile_idx_d  = N_W'(out_cnt);
          if (out_last) begin
            state_d = DONE;
          end else begin
            out_inc = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cfg_err_q   <= 1'b0;
      act_load_q  <= 1'b0;
      tile_done_q <= 1'b0;
      tile_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_err_q   <= cfg_err_d;
      act_load_q  <= act_load_d;
      tile_done_q <= tile_done_d;
      tile_idx_q  <= tile_idx_d;
    end
  end
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with a job-level reference model and a reactive memory/accumulator.
module tb_tile_sequencer;
  logic       clk, reset, start, abort;
  logic [3:0] cfg_k;
  logic [4:0] cfg_n;
  logic [9:0] cfg_base;
  logic       busy, done, cfg_err, mem_rd_en, mem_rd_gnt, acc_act_load, acc_ready, out_tile_done;
  logic [9:0] mem_rd_addr;
  logic [3:0] acc_num_input_tiles;
  logic [4:0] out_tile_idx;

  tile_sequencer #(.ADDR_W(10), .MAX_INPUT_TILES(4), .MAX_OUTPUT_TILES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_num_in_tiles(cfg_k), .cfg_num_out_tiles(cfg_n), .cfg_base_addr(cfg_base),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .acc_act_load(acc_act_load), .acc_num_input_tiles(acc_num_input_tiles),
    .acc_ready(acc_ready), .out_tile_done(out_tile_done), .out_tile_idx(out_tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // observation logs
  int addr_log[$];
  int stall_log[$];
  int idx_log[$];
  int act_cnt, done_cnt, err_cnt, busy_cnt, rd_cnt;

  // environment configuration
  int ready_always = 0;
  int ready_delay  = 4;
  int job_k        = 1;
  int stall_at     = -1;
  int stall_len    = 0;

  // reference model: job-level view in terms of granted reads and finished tiles
  bit m_valid = 0;
  bit m_active, m_waiting, m_finishing, m_load_pend, m_err_pend, m_td_pend;
  int m_k, m_n, m_base, m_tile, m_r, m_td_idx;

  initial begin
    bit exp_rd, nl, ne, bad;
    int exp_addr;
    forever begin
      @(negedge clk);
      exp_rd   = m_active && !m_waiting && !m_finishing;
      exp_addr = (m_base + m_tile * m_k + m_r) % 1024;
      if (m_valid) begin
        check("busy", int'(busy), int'(m_active));
        check("mem_rd_en", int'(mem_rd_en), int'(exp_rd));
        if (exp_rd) check("mem_rd_addr", int'(mem_rd_addr), exp_addr);
        check("acc_act_load", int'(acc_act_load), int'(m_load_pend));
        check("out_tile_done", int'(out_tile_done), int'(m_td_pend));
        if (m_td_pend) check("out_tile_idx", int'(out_tile_idx), m_td_idx);
        check("done", int'(done), int'(m_finishing));
        check("cfg_err", int'(cfg_err), int'(m_err_pend));
        check("acc_num_input_tiles", int'(acc_num_input_tiles), m_k);
      end
      if (mem_rd_en === 1'b1 && mem_rd_gnt) addr_log.push_back(int'(mem_rd_addr));
      if (mem_rd_en === 1'b1 && !mem_rd_gnt) stall_log.push_back(int'(mem_rd_addr));
      if (acc_act_load === 1'b1) act_cnt++;
      if (done === 1'b1) done_cnt++;
      if (cfg_err === 1'b1) err_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (mem_rd_en === 1'b1) rd_cnt++;
      if (out_tile_done === 1'b1) idx_log.push_back(int'(out_tile_idx));

      bad = (cfg_k == 0) || (cfg_k > 4) || (cfg_n == 0) || (cfg_n > 16);
      nl  = exp_rd && mem_rd_gnt;
      ne  = !m_active && start && bad;
      if (reset) begin
        m_valid = 1; m_active = 0; m_waiting = 0; m_finishing = 0;
        m_load_pend = 0; m_err_pend = 0; m_td_pend = 0;
        m_k = 0; m_n = 0; m_base = 0; m_tile = 0; m_r = 0; m_td_idx = 0;
      end else if (m_valid) begin
        m_td_pend = 0;
        if (!m_active) begin
          if (start && !bad) begin
            m_active = 1; m_k = int'(cfg_k); m_n = int'(cfg_n); m_base = int'(cfg_base);
            m_tile = 0; m_r = 0; m_waiting = 0; m_finishing = 0;
          end
        end else if (m_finishing) begin
          m_active = 0; m_finishing = 0;
        end else if (abort) begin
          m_active = 0; m_waiting = 0;
        end else if (!m_waiting) begin
          if (mem_rd_gnt) begin
            m_r++;
            if (m_r == m_k) begin m_r = 0; m_waiting = 1; end
          end
        end else if (acc_ready) begin
          m_td_pend = 1; m_td_idx = m_tile;
          if (m_tile == m_n - 1) m_finishing = 1;
          else begin m_tile++; m_waiting = 0; end
        end
        m_load_pend = nl;
        m_err_pend  = ne;
      end
    end
  end

  // reactive memory grant and accumulator ready
  initial begin
    int ld_tile, wc, grants, stall_rem;
    bit stall_used;
    ld_tile = 0; wc = -1; grants = 0; stall_rem = 0; stall_used = 0;
    mem_rd_gnt = 1'b1;
    acc_ready  = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (busy !== 1'b1) begin
        ld_tile = 0; wc = -1; grants = 0; stall_rem = 0; stall_used = 0;
        acc_ready = (ready_always != 0);
      end
      if (acc_act_load === 1'b1) grants++;
      if (ready_always != 0) begin
        acc_ready = 1'b1;
      end else begin
        if (out_tile_done === 1'b1) begin ld_tile = 0; wc = -1; acc_ready = 1'b0; end
        if (acc_act_load === 1'b1) begin
          ld_tile++;
          if (ld_tile == job_k) wc = 0;
        end else if (wc >= 0 && !acc_ready) begin
          wc++;
        end
        if (wc >= ready_delay) acc_ready = 1'b1;
      end
      if (stall_rem > 0) begin
        mem_rd_gnt = 1'b0; stall_rem--;
      end else if (stall_at >= 0 && !stall_used && grants == stall_at && mem_rd_en === 1'b1) begin
        stall_used = 1; stall_rem = stall_len - 1; mem_rd_gnt = 1'b0;
      end else begin
        mem_rd_gnt = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_logs();
    addr_log.delete(); stall_log.delete(); idx_log.delete();
    act_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; rd_cnt = 0;
  endtask

  task automatic start_job(input int k, input int n, input int base);
    job_k = k;
    cfg_k = 4'(k); cfg_n = 5'(n); cfg_base = 10'(base);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_k = 4'hF; cfg_n = 5'h1F; cfg_base = 10'h3AA;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (done_cnt == 0 && c < maxc) begin step(); c++; end
    step(); step();
  endtask

  task automatic check_addrs(input string name, input int exp[$]);
    check({name, "_count"}, addr_log.size(), exp.size());
    foreach (exp[i]) if (i < addr_log.size()) check(name, addr_log[i], exp[i]);
  endtask

  initial begin
    int c;
    int bad_k[3] = '{0, 5, 2};
    int bad_n[3] = '{2, 2, 0};
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_k = '0; cfg_n = '0; cfg_base = '0;
    step(); step(); step();
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_rd_addr", int'(mem_rd_addr), 0);
    check("rst_idx", int'(out_tile_idx), 0);
    check("rst_num_in", int'(acc_num_input_tiles), 0);
    reset = 1'b0;
    step();

    // basic job: K=3, N=2, ready 4 cycles into WAIT_ACC
    clear_logs(); ready_delay = 4; stall_at = -1;
    start_job(3, 2, 'h010);
    wait_done(200);
    check_addrs("t1_addr", '{'h010, 'h011, 'h012, 'h013, 'h014, 'h015});
    check("t1_act_loads", act_cnt, 6);
    check("t1_tiles", idx_log.size(), 2);
    if (idx_log.size() == 2) begin
      check("t1_idx0", idx_log[0], 0);
      check("t1_idx1", idx_log[1], 1);
    end
    check("t1_done", done_cnt, 1);
    check("t1_busy_after", int'(busy), 0);

    // same job, 2-cycle grant stall on the 2nd read
    clear_logs(); stall_at = 1; stall_len = 2;
    start_job(3, 2, 'h010);
    wait_done(200);
    check_addrs("t2_addr", '{'h010, 'h011, 'h012, 'h013, 'h014, 'h015});
    check("t2_stall_cycles", stall_log.size(), 2);
    foreach (stall_log[i]) check("t2_stall_addr", stall_log[i], 'h011);
    check("t2_act_loads", act_cnt, 6);
    check("t2_done", done_cnt, 1);
    stall_at = -1;

    // address wrap
    clear_logs(); ready_delay = 0;
    start_job(4, 1, 'h3FE);
    wait_done(100);
    check_addrs("t3_addr", '{'h3FE, 'h3FF, 'h000, 'h001});
    check("t3_done", done_cnt, 1);

    // rejected configurations
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      start_job(bad_k[i], bad_n[i], 'h050);
      repeat (5) step();
      check("t4_cfg_err", err_cnt, 1);
      check("t4_busy_cycles", busy_cnt, 0);
      check("t4_rd_cycles", rd_cnt, 0);
    end

    // abort in 2nd tile's ISSUE, then restart with start+abort together
    clear_logs(); ready_delay = 1;
    start_job(2, 4, 'h100);
    c = 0;
    while (!(idx_log.size() >= 1 && mem_rd_en === 1'b1) && c < 100) begin step(); c++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_busy", int'(busy), 0);
    repeat (10) step();
    check("t5_done", done_cnt, 0);
    check("t5_tiles", idx_log.size(), 1);
    check("t5_act_loads", act_cnt, 4);
    clear_logs();
    abort = 1'b1;
    start_job(2, 1, 'h200);
    abort = 1'b0;
    wait_done(100);
    check_addrs("t5_restart_addr", '{'h200, 'h201});
    check("t5_restart_done", done_cnt, 1);

    // ready held high from reset
    ready_always = 1;
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    clear_logs();
    start_job(2, 1, 'h020);
    c = 0;
    while (out_tile_done !== 1'b1 && c < 20) begin step(); c++; end
    check("t6_tile_latency", c, 3);
    check("t6_act_before_tile", act_cnt, 2);
    wait_done(50);
    check("t6_done", done_cnt, 1);

    // reset in the middle of ISSUE
    start_job(4, 2, 'h030);
    step();
    reset = 1'b1;
    step();
    check("t7_busy", int'(busy), 0);
    check("t7_done", int'(done), 0);
    check("t7_cfg_err", int'(cfg_err), 0);
    check("t7_rd_en", int'(mem_rd_en), 0);
    check("t7_act_load", int'(acc_act_load), 0);
    check("t7_tile_done", int'(out_tile_done), 0);
    check("t7_rd_addr", int'(mem_rd_addr), 0);
    check("t7_idx", int'(out_tile_idx), 0);
    check("t7_num_in", int'(acc_num_input_tiles), 0);
    reset = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
